count_chain: RTL and testbench

COUNT_CHAIN -- requirements
Module: count_chain

---
 rtl/count_pkg.sv | 13 +
 rtl/count_digit.sv | 40 ++++
 rtl/count_chain.sv | 70 +++++++
 tb/tb_count_chain.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared defaults for the cascaded counter: digit width, chain length and terminal values.
package count_pkg;

    localparam int unsigned FIELD_W    = 4;
    localparam int unsigned DIGITS_DEF = 2;
    localparam logic [DIGITS_DEF*FIELD_W-1:0] MAXV_DEF = {4'd5, 4'd9};

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/count_digit.sv
// Single mod-(MAXV+1) digit with up/down step, clamped parallel load and terminal decode.
module count_digit
    import count_pkg::*;
#(
    parameter int unsigned      DW   = FIELD_W,
    parameter logic [DW-1:0]    MAXV = '1
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_step,
    input  logic          i_up_dn,
    input  logic          i_load,
    input  logic [DW-1:0] i_load_val,
    output logic [DW-1:0] o_value,
    output logic          o_term,
    output logic          o_clamp
);

    logic [DW-1:0] r_value;
    logic          w_up;

    assign w_up    = (dir_e'(i_up_dn) == DIR_UP);
    assign o_clamp = (i_load_val > MAXV);
    assign o_term  = w_up ? (r_value == MAXV) : (r_value == '0);
    assign o_value = r_value;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= o_clamp ? MAXV : i_load_val;
        end else if (i_step) begin
            if (w_up)
                r_value <= (r_value == MAXV) ? '0 : r_value + DW'(1);
            else
                r_value <= (r_value == '0) ? MAXV : r_value - DW'(1);
        end
    end

endmodule

// File: rtl/count_chain.sv
// Synchronous cascade of count_digit instances with chain terminal decode, wrap pulse and load-error flag.
module count_chain
    import count_pkg::*;
#(
    parameter int unsigned                DIGITS = DIGITS_DEF,
    parameter int unsigned                DW     = FIELD_W,
    parameter logic [DIGITS*DW-1:0]       MAXV   = MAXV_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 up_dn,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] load_val,
    output logic [DIGITS*DW-1:0] count,
    output logic                 co,
    output logic                 tc_pulse,
    output logic                 err
);

    logic [DIGITS-1:0] w_carry;
    logic [DIGITS-1:0] w_term;
    logic [DIGITS-1:0] w_clamp;
    logic              r_tc;
    logic              r_err;

    // Digit i steps only when every lower digit sits at its terminal.
    always_comb begin
        w_carry    = '0;
        w_carry[0] = en & ~load;
        for (int unsigned i = 1; i < DIGITS; i++)
            w_carry[i] = w_carry[i-1] & w_term[i-1];
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            count_digit #(
                .DW   (DW),
                .MAXV (MAXV[gi*DW +: DW])
            ) u_digit (
                .clk        (clk),
                .i_rst      (rst),
                .i_step     (w_carry[gi]),
                .i_up_dn    (up_dn),
                .i_load     (load),
                .i_load_val (load_val[gi*DW +: DW]),
                .o_value    (count[gi*DW +: DW]),
                .o_term     (w_term[gi]),
                .o_clamp    (w_clamp[gi])
            );
        end
    endgenerate

    assign co       = &w_term;
    assign tc_pulse = r_tc;
    assign err      = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tc  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_tc <= en & ~load & co;
            if (load && (|w_clamp))
                r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_count_chain.sv
// Scoreboard bench for count_chain at default parameters (decimal 0..59 chain).
module tb_count_chain;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic [7:0] count;
    logic       co;
    logic       tc_pulse;
    logic       err;

    typedef struct {
        logic [7:0] cnt;
        logic       tc;
        logic       er;
        logic       c;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_v = 0;
    bit   m_err = 1'b0;

    count_chain #(
        .DIGITS (2),
        .DW     (4),
        .MAXV   (8'h59)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .co       (co),
        .tc_pulse (tc_pulse),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    // Drive one edge worth of inputs, predict, then compare after the edge.
    task automatic cyc(input bit r, input bit e, input bit u, input bit l, input logic [7:0] lv);
        exp_t x;
        bit   co_pre;
        int   hi;
        int   lo;
        rst = r; en = e; up_dn = u; load = l; load_val = lv;
        co_pre = u ? (m_v == 59) : (m_v == 0);
        if (r) begin
            m_v = 0; m_err = 1'b0; x.tc = 1'b0;
        end else if (l) begin
            hi = int'(lv[7:4]); lo = int'(lv[3:0]);
            if (hi > 5 || lo > 9) m_err = 1'b1;
            if (hi > 5) hi = 5;
            if (lo > 9) lo = 9;
            m_v = hi * 10 + lo;
            x.tc = 1'b0;
        end else begin
            x.tc = e & co_pre;
            if (e) begin
                if (u) m_v = (m_v == 59) ? 0 : m_v + 1;
                else   m_v = (m_v == 0) ? 59 : m_v - 1;
            end
        end
        x.cnt = to_bcd(m_v);
        x.er  = m_err;
        x.c   = u ? (m_v == 59) : (m_v == 0);
        q.push_back(x);
        @(posedge clk);
        #1;
        x = q.pop_front();
        chk("count", 32'(count), 32'(x.cnt));
        chk("tc_pulse", 32'(tc_pulse), 32'(x.tc));
        chk("err", 32'(err), 32'(x.er));
        chk("co", 32'(co), 32'(x.c));
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset, then co must follow up_dn combinationally.
        cyc(1, 0, 1, 0, 8'h00);
        chk("rst_count", 32'(count), 32'h00);
        chk("rst_co_up", 32'(co), 32'd0);
        up_dn = 1'b0;
        #1;
        chk("rst_co_dn", 32'(co), 32'd1);

        // Full up traversal and wrap.
        for (int i = 0; i < 59; i++) cyc(0, 1, 1, 0, 8'h00);
        chk("up_at59", 32'(count), 32'h59);
        chk("up_co59", 32'(co), 32'd1);
        cyc(0, 1, 1, 0, 8'h00);
        chk("up_wrap", 32'(count), 32'h00);
        chk("up_wrap_tc", 32'(tc_pulse), 32'd1);
        cyc(0, 0, 1, 0, 8'h00);
        chk("tc_one_cycle", 32'(tc_pulse), 32'd0);

        // Down wrap from zero, then tens borrow.
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        chk("dn_wrap", 32'(count), 32'h59);
        chk("dn_wrap_tc", 32'(tc_pulse), 32'd1);
        cyc(0, 0, 0, 1, 8'h10);
        cyc(0, 1, 0, 0, 8'h00);
        chk("dn_borrow", 32'(count), 32'h09);

        // Clamped loads and sticky err.
        cyc(0, 0, 1, 1, 8'h7A);
        chk("clamp_val", 32'(count), 32'h59);
        chk("clamp_err", 32'(err), 32'd1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 8'h12);
        chk("err_sticky", 32'(err), 32'd1);
        cyc(0, 1, 1, 1, 8'h59);
        chk("load_at_term_tc", 32'(tc_pulse), 32'd0);

        // Load beats enable.
        cyc(1, 0, 1, 0, 8'h00);
        cyc(0, 1, 1, 1, 8'h30);
        chk("load_no_step", 32'(count), 32'h30);

        // Reset overrides load and enable mid-count, then hold.
        cyc(0, 0, 1, 1, 8'h36);
        cyc(0, 1, 1, 0, 8'h00);
        chk("at37", 32'(count), 32'h37);
        cyc(1, 1, 1, 1, 8'h44);
        chk("rst_override", 32'(count), 32'h00);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 8'h00);
        chk("hold_zero", 32'(count), 32'h00);

        // Random mix including direction flips and out-of-range loads.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0),
                8'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
